// File: rtl/packet_sequencer_if.sv
// Handshake and data bundle between packet_sequencer and its neighbours:
// RX FIFO, PC_TX serialiser, SLM config port and error status.
interface packet_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
);
    logic              i_rx_fifo_is_empty_sig;
    logic [DATA_W-1:0] i_rx_fifo_output_word;
    logic              o_rx_fifo_next_word_cmd;
    logic              i_serial_is_busy_sig;
    logic              o_tx_start;
    logic [DATA_W-1:0] o_tx_word;
    logic              o_cfg_wr;
    logic [LEN_W-1:0]  o_cfg_addr;
    logic [DATA_W-1:0] o_cfg_data;
    logic              o_packet_done;
    logic              o_busy;
    logic              i_err_clr;
    logic              o_err_cmd;
    logic              o_err_addr;

    modport master (
        input  i_rx_fifo_is_empty_sig,
        input  i_rx_fifo_output_word,
        output o_rx_fifo_next_word_cmd,
        input  i_serial_is_busy_sig,
        output o_tx_start,
        output o_tx_word,
        output o_cfg_wr,
        output o_cfg_addr,
        output o_cfg_data,
        output o_packet_done,
        output o_busy,
        input  i_err_clr,
        output o_err_cmd,
        output o_err_addr
    );

    modport slave (
        output i_rx_fifo_is_empty_sig,
        output i_rx_fifo_output_word,
        input  o_rx_fifo_next_word_cmd,
        output i_serial_is_busy_sig,
        input  o_tx_start,
        input  o_tx_word,
        input  o_cfg_wr,
        input  o_cfg_addr,
        input  o_cfg_data,
        input  o_packet_done,
        input  o_busy,
        output i_err_clr,
        input  o_err_cmd,
        input  o_err_addr
    );
endinterface

// File: rtl/packet_sequencer.sv
// Frames the RX FIFO word stream into cmd/len/payload packets and routes
// payload words to the TX serialiser (echo) or the config write port.
module packet_sequencer #(
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int CFG_DEPTH = 256
) (
    input logic           i_clock,
    input logic           i_reset,
    packet_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        S_CMD,
        S_LEN,
        S_PAYLOAD
    } state_t;

    localparam logic [1:0] CMD_ECHO = 2'd1;
    localparam logic [1:0] CMD_CFG  = 2'd2;
    localparam logic [1:0] CMD_RSV  = 2'd3;
    localparam logic [LEN_W:0] DEPTH = (LEN_W+1)'(CFG_DEPTH);

    state_t state;
    state_t state_nxt;

    logic [1:0]        cmd;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  index;
    logic              tx_start;
    logic [DATA_W-1:0] tx_word;
    logic              cfg_wr;
    logic [LEN_W-1:0]  cfg_addr;
    logic [DATA_W-1:0] cfg_data;
    logic              packet_done;
    logic              err_cmd;
    logic              err_addr;

    logic              empty;
    logic [DATA_W-1:0] word;
    logic              ser_busy;
    logic              pop;
    logic              done_nxt;
    logic              tx_guard;
    logic              in_range;
    logic              is_echo;
    logic              is_cfg;
    logic              set_cmd;
    logic              set_addr;

    assign empty    = bus.i_rx_fifo_is_empty_sig;
    assign word     = bus.i_rx_fifo_output_word;
    assign ser_busy = bus.i_serial_is_busy_sig;

    // busy only rises the cycle after start, so the start cycle is blanked
    assign tx_guard = tx_start;
    assign in_range = {1'b0, index} < DEPTH;
    assign is_echo  = cmd == CMD_ECHO;
    assign is_cfg   = cmd == CMD_CFG;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        done_nxt  = 1'b0;
        unique case (state)
            S_CMD: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (word[LEN_W-1:0] == '0) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_CMD;
                    end else begin
                        state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (!empty && (!is_echo || (!ser_busy && !tx_guard))) begin
                    pop = 1'b1;
                    if (remaining == LEN_W'(1)) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_CMD;
                    end
                end
            end
            default: state_nxt = S_CMD;
        endcase
        if (i_reset) begin
            pop       = 1'b0;
            done_nxt  = 1'b0;
            state_nxt = S_CMD;
        end
    end

    assign set_cmd  = pop && state == S_CMD && word[1:0] == CMD_RSV;
    assign set_addr = pop && state == S_PAYLOAD && is_cfg && !in_range;

    always_ff @(posedge i_clock) begin
        if (i_reset) state <= S_CMD;
        else         state <= state_nxt;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cmd         <= '0;
            remaining   <= '0;
            index       <= '0;
            tx_start    <= 1'b0;
            tx_word     <= '0;
            cfg_wr      <= 1'b0;
            cfg_addr    <= '0;
            cfg_data    <= '0;
            packet_done <= 1'b0;
            err_cmd     <= 1'b0;
            err_addr    <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            cfg_wr      <= 1'b0;
            packet_done <= done_nxt;
            err_cmd     <= set_cmd | (err_cmd & ~bus.i_err_clr);
            err_addr    <= set_addr | (err_addr & ~bus.i_err_clr);
            if (pop) begin
                unique case (state)
                    S_CMD: cmd <= word[1:0];
                    S_LEN: begin
                        remaining <= word[LEN_W-1:0];
                        index     <= '0;
                    end
                    S_PAYLOAD: begin
                        remaining <= remaining - LEN_W'(1);
                        unique case (1'b1)
                            is_echo: begin
                                tx_start <= 1'b1;
                                tx_word  <= word;
                            end
                            is_cfg: begin
                                index <= index + LEN_W'(1);
                                if (in_range) begin
                                    cfg_wr   <= 1'b1;
                                    cfg_addr <= index;
                                    cfg_data <= word;
                                end
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_rx_fifo_next_word_cmd = pop;
    assign bus.o_tx_start    = tx_start;
    assign bus.o_tx_word     = tx_word;
    assign bus.o_cfg_wr      = cfg_wr;
    assign bus.o_cfg_addr    = cfg_addr;
    assign bus.o_cfg_data    = cfg_data;
    assign bus.o_packet_done = packet_done;
    assign bus.o_busy        = state != S_CMD;
    assign bus.o_err_cmd     = err_cmd;
    assign bus.o_err_addr    = err_addr;
endmodule

// File: tb/tb_packet_sequencer.sv
// Scoreboard bench: packets are expanded into expected TX/config/done
// events when queued; a monitor pops and compares as the DUT emits them.
module tb_packet_sequencer;
    localparam int DATA_W    = 32;
    localparam int LEN_W     = 16;
    localparam int CFG_DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    packet_sequencer_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) sif();

    packet_sequencer #(
        .DATA_W(DATA_W),
        .LEN_W(LEN_W),
        .CFG_DEPTH(CFG_DEPTH)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus(sif)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] fifo[$];
    logic [31:0] pl[$];
    logic [31:0] exp_tx[$];
    logic [47:0] exp_cfg[$];
    int exp_done = 0;
    bit exp_err_cmd = 0;
    bit exp_err_addr = 0;

    bit will_pop = 0;
    bit busy_auto = 0;
    bit busy_manual = 0;
    bit rand_stall = 0;
    int busy_cnt = 0;
    int pop_cnt = 0;
    int cyc = 0;
    int tx_cnt = 0;
    int cfg_cnt = 0;
    int done_cnt = 0;
    int last_start = -100;
    int first_cfg = -1;
    int last_cfg = -1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        tests++;
        fails++;
        $display("FAIL %s: event not expected or not reached", name);
    endtask

    // reference: a packet expands into the events it must produce
    task automatic send(input logic [31:0] cmdw, input logic [31:0] lenw);
        case (cmdw[1:0])
            2'd1: foreach (pl[i]) exp_tx.push_back(pl[i]);
            2'd2: foreach (pl[i]) begin
                if (i < CFG_DEPTH) exp_cfg.push_back({16'(i), pl[i]});
                else exp_err_addr = 1'b1;
            end
            2'd3: exp_err_cmd = 1'b1;
            default: ;
        endcase
        exp_done++;
        fifo.push_back(cmdw);
        fifo.push_back(lenw);
        foreach (pl[i]) fifo.push_back(pl[i]);
    endtask

    task automatic wait_idle(string name);
        bit idle = 0;
        for (int i = 0; i < 3000 && !idle; i++) begin
            @(negedge clk);
            #3;
            if (fifo.size() == 0 && !sif.o_busy && exp_tx.size() == 0 &&
                exp_cfg.size() == 0 && exp_done == 0)
                idle = 1;
        end
        if (!idle) fail_now({name, "_idle_timeout"});
        repeat (2) @(negedge clk);
        #2;
    endtask

    task automatic wait_tx(int target, string name);
        bit hit = 0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            #2;
            if (tx_cnt >= target) hit = 1;
        end
        if (!hit) fail_now({name, "_tx_timeout"});
    endtask

    task automatic clear_errs(string name);
        @(negedge clk);
        sif.i_err_clr = 1'b1;
        exp_err_cmd = 1'b0;
        exp_err_addr = 1'b0;
        @(negedge clk);
        sif.i_err_clr = 1'b0;
        @(negedge clk);
        #2;
        check({name, "_err_cmd_clr"}, 64'(sif.o_err_cmd), 64'(0));
        check({name, "_err_addr_clr"}, 64'(sif.o_err_addr), 64'(0));
    endtask

    task automatic check_flags(string name);
        check({name, "_err_cmd"}, 64'(sif.o_err_cmd), 64'(exp_err_cmd));
        check({name, "_err_addr"}, 64'(sif.o_err_addr), 64'(exp_err_addr));
    endtask

    task automatic check_zero(string name);
        check({name, "_tx_start"}, 64'(sif.o_tx_start), 64'(0));
        check({name, "_tx_word"}, 64'(sif.o_tx_word), 64'(0));
        check({name, "_cfg_wr"}, 64'(sif.o_cfg_wr), 64'(0));
        check({name, "_cfg_addr"}, 64'(sif.o_cfg_addr), 64'(0));
        check({name, "_cfg_data"}, 64'(sif.o_cfg_data), 64'(0));
        check({name, "_done"}, 64'(sif.o_packet_done), 64'(0));
        check({name, "_busy"}, 64'(sif.o_busy), 64'(0));
        check({name, "_err_cmd"}, 64'(sif.o_err_cmd), 64'(0));
        check({name, "_err_addr"}, 64'(sif.o_err_addr), 64'(0));
    endtask

    // FIFO and serialiser models; inputs change only on negedge
    initial begin
        logic [31:0] tmp;
        forever begin
            @(negedge clk);
            if (will_pop) begin
                if (fifo.size() > 0) tmp = fifo.pop_front();
                pop_cnt++;
            end
            if (busy_auto) begin
                if (busy_cnt > 0) busy_cnt--;
                if (sif.o_tx_start) busy_cnt = $urandom_range(1, 4);
                sif.i_serial_is_busy_sig = busy_cnt > 0;
            end else begin
                sif.i_serial_is_busy_sig = busy_manual;
            end
            sif.i_rx_fifo_is_empty_sig = fifo.size() == 0 ||
                (rand_stall && $urandom_range(0, 3) == 0);
            sif.i_rx_fifo_output_word = fifo.size() != 0 ? fifo[0] : $urandom();
            #1;
            will_pop = sif.o_rx_fifo_next_word_cmd;
            if (will_pop)
                check("pop_while_empty", 64'(sif.i_rx_fifo_is_empty_sig), 64'(0));
        end
    end

    // monitor: pops expected events whenever the DUT presents one
    initial begin
        logic [31:0] et;
        logic [47:0] ec;
        forever begin
            @(negedge clk);
            cyc++;
            if (sif.o_tx_start) begin
                if (exp_tx.size() == 0) begin
                    fail_now("tx_unexpected");
                end else begin
                    et = exp_tx.pop_front();
                    check("tx_word", 64'(sif.o_tx_word), 64'(et));
                end
                check("tx_spacing", 64'(cyc - last_start >= 2), 64'(1));
                check("tx_latency", 64'(will_pop), 64'(1));
                last_start = cyc;
                tx_cnt++;
            end
            if (sif.o_cfg_wr) begin
                if (exp_cfg.size() == 0) begin
                    fail_now("cfg_unexpected");
                end else begin
                    ec = exp_cfg.pop_front();
                    check("cfg_addr_data",
                          64'({sif.o_cfg_addr, sif.o_cfg_data}), 64'(ec));
                end
                check("cfg_latency", 64'(will_pop), 64'(1));
                if (first_cfg < 0) first_cfg = cyc;
                last_cfg = cyc;
                cfg_cnt++;
            end
            if (sif.o_packet_done) begin
                tests++;
                if (exp_done == 0) begin
                    fails++;
                    $display("FAIL done_unexpected: got pulse expected none");
                end else begin
                    exp_done--;
                end
                done_cnt++;
            end
        end
    end

    initial begin
        int t0;
        int c0;
        int d0;
        int p0;
        int n;
        logic [31:0] r;
        logic [31:0] cw;
        sif.i_err_clr = 1'b0;
        sif.i_serial_is_busy_sig = 1'b0;
        sif.i_rx_fifo_is_empty_sig = 1'b1;
        sif.i_rx_fifo_output_word = '0;

        // echo of three words, FIFO preloaded while in reset
        t0 = tx_cnt;
        d0 = done_cnt;
        pl = '{32'hA, 32'hB, 32'hC};
        send(32'h1, 32'h3);
        repeat (3) @(negedge clk);
        #2;
        check("pop_in_reset", 64'(will_pop), 64'(0));
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        wait_idle("echo3");
        check("echo3_starts", 64'(tx_cnt - t0), 64'(3));
        check("echo3_done", 64'(done_cnt - d0), 64'(1));

        // busy held for 20 cycles after the first start
        t0 = tx_cnt;
        pl = '{32'hA1, 32'hB2};
        send(32'h1, 32'h2);
        wait_tx(t0 + 1, "hold");
        busy_manual = 1'b1;
        p0 = pop_cnt;
        repeat (20) @(negedge clk);
        #2;
        check("hold_no_pop", 64'(pop_cnt - p0), 64'(0));
        check("hold_no_start", 64'(tx_cnt - t0), 64'(1));
        busy_manual = 1'b0;
        wait_idle("hold");
        check("hold_second_start", 64'(tx_cnt - t0), 64'(2));

        // config streamed back to back
        c0 = cfg_cnt;
        first_cfg = -1;
        pl = '{32'h11, 32'h22, 32'h33, 32'h44};
        send(32'h2, 32'h4);
        wait_idle("cfg4");
        check("cfg4_count", 64'(cfg_cnt - c0), 64'(4));
        check("cfg4_consecutive", 64'(last_cfg - first_cfg), 64'(3));

        // config beyond depth: words past the end are consumed, flag set
        c0 = cfg_cnt;
        p0 = pop_cnt;
        pl.delete();
        repeat (6) pl.push_back($urandom());
        send(32'h2, 32'h6);
        wait_idle("cfg_oob");
        check("cfg_oob_pops", 64'(pop_cnt - p0), 64'(8));
        check("cfg_oob_writes", 64'(cfg_cnt - c0), 64'(CFG_DEPTH));
        check_flags("cfg_oob");
        clear_errs("cfg_oob");

        // reserved command followed by an empty echo
        t0 = tx_cnt;
        d0 = done_cnt;
        pl = '{32'h5};
        send(32'h3, 32'h1);
        pl.delete();
        send(32'h1, 32'h0);
        wait_idle("rsv");
        check_flags("rsv");
        check("rsv_no_start", 64'(tx_cnt - t0), 64'(0));
        check("rsv_done", 64'(done_cnt - d0), 64'(2));
        clear_errs("rsv");

        // reset in the middle of an echo packet
        t0 = tx_cnt;
        pl = '{32'hA, 32'hB, 32'hC};
        send(32'h1, 32'h3);
        wait_tx(t0 + 1, "midrst");
        busy_manual = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #2;
        check("midrst_no_pop", 64'(will_pop), 64'(0));
        fifo.delete();
        exp_tx.delete();
        exp_cfg.delete();
        exp_done = 0;
        exp_err_cmd = 1'b0;
        exp_err_addr = 1'b0;
        busy_manual = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
        #2;
        c0 = cfg_cnt;
        pl = '{32'h99};
        send(32'h2, 32'h1);
        wait_idle("midrst");
        check("midrst_cfg_after", 64'(cfg_cnt - c0), 64'(1));

        // randomized traffic with FIFO stalls and a busy serialiser
        busy_auto = 1'b1;
        rand_stall = 1'b1;
        for (int k = 0; k < 40; k++) begin
            n = $urandom_range(0, 6);
            pl.delete();
            repeat (n) pl.push_back($urandom());
            cw = $urandom();
            r = $urandom();
            send(cw, {r[31:16], 16'(n)});
            if (k % 10 == 9) begin
                wait_idle("rand");
                check_flags("rand");
                clear_errs("rand");
            end
        end
        check("rand_leftover",
              64'(exp_tx.size() + exp_cfg.size() + exp_done), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/packet_sequencer.md
Name: packet_sequencer

Overview:
Controller that sequences the PC_RX word FIFO into framed packets of three parts: a command word, a length word, then a payload of N words. Each payload is routed to one of two destinations: the PC_TX serialiser (echo) or the SLM configuration write port (config). It sits between the RX FIFO / packet decoder and the PC_TX and SLM_CONFIG sub-blocks. It replaces free-running single-word loopback with flow-controlled, multi-word handling.

Parameters:
DATA_W, 32, width of FIFO words, TX words and config data
LEN_W, 16, width of the length field (bits [LEN_W-1:0] of the length word)
CFG_DEPTH, 256, number of valid config addresses (0..CFG_DEPTH-1)

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_rx_fifo_is_empty_sig  in  1  RX FIFO empty (show-ahead FIFO)
i_rx_fifo_output_word  in  DATA_W  RX FIFO head word, valid while not empty
o_rx_fifo_next_word_cmd  out  1  pop strobe; the head word is consumed in the same cycle
i_serial_is_busy_sig  in  1  PC_TX serialiser busy
o_tx_start  out  1  registered 1-cycle pulse: start serialising o_tx_word
o_tx_word  out  DATA_W  registered word for PC_TX, held until next start
o_cfg_wr  out  1  registered 1-cycle config write strobe
o_cfg_addr  out  LEN_W  config address (payload index)
o_cfg_data  out  DATA_W  config data
o_packet_done  out  1  registered 1-cycle pulse at packet completion
o_busy  out  1  high whenever state is not S_CMD
i_err_clr  in  1  clears sticky error flags
o_err_cmd  out  1  sticky: reserved command received
o_err_addr  out  1  sticky: config index >= CFG_DEPTH

Behaviour:
- Reset (i_reset high at a clock edge): state = S_CMD, counters = 0. All registered outputs = 0, including o_tx_word, o_cfg_addr and o_cfg_data. Sticky errors are cleared.
- o_rx_fifo_next_word_cmd is combinational from the registered state and i_rx_fifo_is_empty_sig. It is never high while i_reset is high or the FIFO is empty.
- Commands are decoded from command word bits [1:0]:
  - 0 = NOP: drain payload
  - 1 = ECHO
  - 2 = CONFIG
  - 3 = reserved: set o_err_cmd, drain payload
- States:
  - S_CMD: when not empty, pop and latch cmd -> S_LEN.
  - S_LEN: when not empty, pop and latch N = word[LEN_W-1:0], index = 0.
    - If N == 0: pulse o_packet_done next cycle -> S_CMD.
    - Otherwise -> S_PAYLOAD.
  - S_PAYLOAD: consumes one word per pop.
    - After each pop, remaining is decremented.
    - On the pop with remaining == 1, o_packet_done pulses the next cycle and the state -> S_CMD.
- ECHO pop condition (all must hold):
  - FIFO not empty
  - i_serial_is_busy_sig == 0
  - tx_guard == 0, where tx_guard is set the cycle o_tx_start is high. This blanks one cycle because busy rises one cycle after start.
  - On pop, the next cycle has o_tx_start = 1 and o_tx_word = popped word.
  - Maximum rate is one word per 2 cycles, further limited by busy.
- CONFIG: pop whenever not empty (one word per cycle).
  - The next cycle has o_cfg_wr = 1, o_cfg_addr = index, o_cfg_data = word; index then increments.
  - If index >= CFG_DEPTH: o_cfg_wr stays 0, o_err_addr is set, and the word is still consumed.
- NOP/reserved payload words: popped one per cycle and discarded.
- Empty FIFO in any state: wait, hold state, no pops.
- The remaining-word counter is LEN_W bits. N = 2^LEN_W - 1 is legal, with no wrap before completion.
- Sticky flags: if i_err_clr and a set event occur in the same cycle, set wins.
- Mid-packet reset: the packet is abandoned and the next non-empty word is treated as a command. No pop occurs in the reset cycle.
- Latency: first payload word pop to o_tx_start or o_cfg_wr is exactly 1 cycle.

Test Plan:
- FIFO preloaded {0x1, 0x3, 0xA, 0xB, 0xC}, busy held low after each start + 1 cycle:
  - o_tx_start pulses 3 times with words 0xA, 0xB, 0xC
  - consecutive starts are at least 2 cycles apart
  - o_packet_done pulses once
- ECHO N = 2 with i_serial_is_busy_sig held high for 20 cycles after the first start:
  - no pop and no second start during the hold
  - second start 1 cycle after the first pop following busy falling
- CONFIG {0x2, 0x4, 0x11, 0x22, 0x33, 0x44} streamed back-to-back:
  - o_cfg_wr high on 4 consecutive cycles
  - addr/data = 0/0x11, 1/0x22, 2/0x33, 3/0x44
- CONFIG with CFG_DEPTH = 2 and N = 3:
  - writes at addr 0 and 1 only
  - o_err_addr = 1 after the third pop
  - all 5 words popped
  - i_err_clr clears the flag
- {0x3, 0x1, 0x5} followed by {0x1, 0x0}:
  - o_err_cmd = 1, 0x5 discarded
  - both packets pulse o_packet_done, no o_tx_start
- i_reset asserted mid-ECHO packet (1 of 3 payload words sent):
  - all outputs are 0 the cycle after reset
  - next FIFO word 0x2 is decoded as the CONFIG command
